// File: rtl/frontend_redirect_recv_pkg.sv
// Shared types for the frontend redirect receiver: FSM states, branch-update FIFO entry and
// the ROB-index age compare (the same rule the backend uses, so both sides agree on "older").
// Widths here are the defaults the top module's width parameters assume.
package frontend_redirect_recv_pkg;

    localparam int RR_VADDR_W = 39;
    localparam int RR_FSQ_W   = 5;
    localparam int RR_ROB_W   = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLUSH   = 2'd1,
        RESTART = 2'd2
    } RedirectRecvState;

    typedef struct packed {
        logic                  taken;
        logic [1:0]            br_type;
        logic [1:0]            ras_type;
        logic [RR_VADDR_W-1:0] target;
        logic [RR_FSQ_W-1:0]   fsq_idx;
    } BranchUpdEntry;

    // robIdx = {dir, idx}. Same lap (dir equal): smaller idx is older. Different lap: the
    // entry with the larger idx was allocated on the previous lap, so it is older.
    // Equal indices are never "older".
    function automatic logic robidx_older(input logic [RR_ROB_W:0] a,
                                          input logic [RR_ROB_W:0] b);
        logic res;
        if (a[RR_ROB_W] != b[RR_ROB_W]) begin
            res = (a[RR_ROB_W-1:0] > b[RR_ROB_W-1:0]);
        end else begin
            res = (a[RR_ROB_W-1:0] < b[RR_ROB_W-1:0]);
        end
        return res;
    endfunction

endpackage

// File: rtl/frontend_redirect_recv_upd_fifo.sv
// Purpose: small circular FIFO buffering branch-resolution updates toward the BPU.
// Latency: written entry visible at rdata_o the cycle after push (head is combinational read).
// Backpressure: caller must not push when full unless popping the same cycle.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/wdata_i write side;
//        pop_i/rdata_o read side; full_o/empty_o status from dir-bit extended pointers.
module redirect_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: nothing reads it until a push has written it.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/frontend_redirect_recv.sv
// Purpose: latch backend redirects, sequence flush -> FSQ restore -> BPU restart; buffer branch updates.
// Latency: rd_en at T gives fe_flush T+1..T+FLUSH_CYCLES, restore pulse at T+FLUSH_CYCLES, restart from T+FLUSH_CYCLES+1.
// Backpressure: restart held until bpu_rs_ready; updates valid/ready, dropped (upd_drop) when FIFO full.
// Ports: rd_* redirect in; br_*/ras_type_i resolution info in; fe_flush_o, fsq_restore_*_o,
//        bpu_rs_* restart handshake; upd_* branch-update stream; busy_o while recovering.
// Optional: REDIRECT_RECV_PERF_EN adds saturating perf_* counter outputs.
module frontend_redirect_recv
    import frontend_redirect_recv_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int UPD_DEPTH    = 4,
    parameter int VADDR_W      = RR_VADDR_W,
    parameter int FSQ_W        = RR_FSQ_W,
    parameter int ROB_W        = RR_ROB_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               rd_en_i,
    input  logic               rd_csr_i,
    input  logic [ROB_W:0]     rd_rob_idx_i,
    input  logic [FSQ_W-1:0]   rd_fsq_idx_i,
    input  logic [VADDR_W-1:0] rd_target_i,
    input  logic               br_en_i,
    input  logic               br_taken_i,
    input  logic [1:0]         br_type_i,
    input  logic [1:0]         ras_type_i,
    input  logic [VADDR_W-1:0] br_target_i,
    output logic               fe_flush_o,
    output logic               fsq_restore_en_o,
    output logic [FSQ_W-1:0]   fsq_restore_idx_o,
    output logic               bpu_rs_valid_o,
    input  logic               bpu_rs_ready_i,
    output logic [VADDR_W-1:0] bpu_rs_pc_o,
    output logic               upd_valid_o,
    input  logic               upd_ready_i,
    output BranchUpdEntry      upd_data_o,
    output logic               upd_drop_o,
`ifdef REDIRECT_RECV_PERF_EN
    output logic [31:0]        perf_redirects_o,
    output logic [31:0]        perf_ignored_o,
    output logic [31:0]        perf_drops_o,
    output logic [31:0]        perf_flush_cycles_o,
`endif
    output logic               busy_o
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    RedirectRecvState   state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ROB_W:0]     rob_q;
    logic [FSQ_W-1:0]   fsq_q;
    logic [VADDR_W-1:0] pc_q;
    logic               accept;

    // In IDLE any redirect is taken; while recovering only a CSR redirect or an older
    // instruction may override the one in flight.
    assign accept = rd_en_i &&
                    ((state_q == IDLE) || rd_csr_i || robidx_older(rd_rob_idx_i, rob_q));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A newly accepted redirect takes priority over everything, including a restart
    // handshake completing in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_LOAD;
        end else begin
            unique case (state_q)
                FLUSH: begin
                    if (cnt_q == '0) state_d = RESTART;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                RESTART: begin
                    if (bpu_rs_ready_i) state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        fe_flush_o       = 1'b0;
        fsq_restore_en_o = 1'b0;
        bpu_rs_valid_o   = 1'b0;
        unique case (state_q)
            FLUSH: begin
                fe_flush_o       = 1'b1;
                fsq_restore_en_o = (cnt_q == '0);
            end
            RESTART: bpu_rs_valid_o = 1'b1;
            default: ;
        endcase
    end

    assign busy_o            = (state_q != IDLE);
    assign fsq_restore_idx_o = fsq_q;
    assign bpu_rs_pc_o       = pc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rob_q <= '0;
            fsq_q <= '0;
            pc_q  <= '0;
        end else if (accept) begin
            rob_q <= rd_rob_idx_i;
            fsq_q <= rd_fsq_idx_i;
            pc_q  <= rd_target_i;
        end
    end

    // ---- branch-update buffer ----
    BranchUpdEntry fifo_wdata;
    logic [$bits(BranchUpdEntry)-1:0] fifo_rdata;
    logic fifo_full, fifo_empty, fifo_push, fifo_pop, push_req;

    // CSR/exception redirects carry no meaningful branch resolution.
    assign push_req  = br_en_i && !rd_csr_i;
    assign fifo_pop  = !fifo_empty && upd_ready_i;
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign fifo_push = push_req && (!fifo_full || fifo_pop);
    assign upd_drop_o = push_req && fifo_full && !fifo_pop;

    always_comb begin
        fifo_wdata          = '0;
        fifo_wdata.taken    = br_taken_i;
        fifo_wdata.br_type  = br_type_i;
        fifo_wdata.ras_type = ras_type_i;
        fifo_wdata.target   = br_target_i;
        fifo_wdata.fsq_idx  = rd_fsq_idx_i;
    end

    redirect_upd_fifo #(
        .DEPTH (UPD_DEPTH),
        .WIDTH ($bits(BranchUpdEntry))
    ) u_upd_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign upd_valid_o = !fifo_empty;
    // Mask the uninitialised storage so the port reads zero whenever nothing is queued.
    assign upd_data_o  = fifo_empty ? '0 : BranchUpdEntry'(fifo_rdata);

`ifdef REDIRECT_RECV_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_redirects_o    <= '0;
            perf_ignored_o      <= '0;
            perf_drops_o        <= '0;
            perf_flush_cycles_o <= '0;
        end else begin
            if (accept && perf_redirects_o != '1)
                perf_redirects_o <= perf_redirects_o + 1'b1;
            if (rd_en_i && !accept && perf_ignored_o != '1)
                perf_ignored_o <= perf_ignored_o + 1'b1;
            if (upd_drop_o && perf_drops_o != '1)
                perf_drops_o <= perf_drops_o + 1'b1;
            if (fe_flush_o && perf_flush_cycles_o != '1)
                perf_flush_cycles_o <= perf_flush_cycles_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_frontend_redirect_recv.sv
// Directed bench for frontend_redirect_recv: a per-cycle vector table for the redirect FSM
// and age compare, then hand-written sequences for the update FIFO and mid-recovery reset.
module tb_frontend_redirect_recv;
    import frontend_redirect_recv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        rd_en_i, rd_csr_i;
    logic [6:0]  rd_rob_idx_i;
    logic [4:0]  rd_fsq_idx_i;
    logic [38:0] rd_target_i;
    logic        br_en_i, br_taken_i;
    logic [1:0]  br_type_i, ras_type_i;
    logic [38:0] br_target_i;
    logic        fe_flush_o, fsq_restore_en_o, bpu_rs_valid_o, bpu_rs_ready_i;
    logic [4:0]  fsq_restore_idx_o;
    logic [38:0] bpu_rs_pc_o;
    logic        upd_valid_o, upd_ready_i, upd_drop_o, busy_o;
    BranchUpdEntry upd_data_o;
`ifdef REDIRECT_RECV_PERF_EN
    logic [31:0] perf_redirects_o, perf_ignored_o, perf_drops_o, perf_flush_cycles_o;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    frontend_redirect_recv dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rd_en_i(rd_en_i), .rd_csr_i(rd_csr_i), .rd_rob_idx_i(rd_rob_idx_i),
        .rd_fsq_idx_i(rd_fsq_idx_i), .rd_target_i(rd_target_i),
        .br_en_i(br_en_i), .br_taken_i(br_taken_i), .br_type_i(br_type_i),
        .ras_type_i(ras_type_i), .br_target_i(br_target_i),
        .fe_flush_o(fe_flush_o), .fsq_restore_en_o(fsq_restore_en_o),
        .fsq_restore_idx_o(fsq_restore_idx_o), .bpu_rs_valid_o(bpu_rs_valid_o),
        .bpu_rs_ready_i(bpu_rs_ready_i), .bpu_rs_pc_o(bpu_rs_pc_o),
        .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i), .upd_data_o(upd_data_o),
        .upd_drop_o(upd_drop_o),
`ifdef REDIRECT_RECV_PERF_EN
        .perf_redirects_o(perf_redirects_o), .perf_ignored_o(perf_ignored_o),
        .perf_drops_o(perf_drops_o), .perf_flush_cycles_o(perf_flush_cycles_o),
`endif
        .busy_o(busy_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd_en, csr, rdy;
        logic [6:0]  rob;
        logic [4:0]  fsq;
        logic [38:0] tgt;
        logic        e_flush, e_rest, e_rsv, e_busy;
        logic [38:0] e_pc;
        logic [4:0]  e_idx;
    } vec_t;

    function automatic vec_t mkv(input logic rd_en, input logic csr, input logic [6:0] rob,
                                 input logic [4:0] fsq, input logic [38:0] tgt, input logic rdy,
                                 input logic ef, input logic er, input logic ev, input logic eb,
                                 input logic [38:0] epc, input logic [4:0] eidx);
        vec_t v;
        v.rd_en = rd_en; v.csr = csr; v.rob = rob; v.fsq = fsq; v.tgt = tgt; v.rdy = rdy;
        v.e_flush = ef; v.e_rest = er; v.e_rsv = ev; v.e_busy = eb; v.e_pc = epc; v.e_idx = eidx;
        return v;
    endfunction

    function automatic BranchUpdEntry mk(input int i);
        BranchUpdEntry e;
        e.taken    = 1'(i & 1);
        e.br_type  = 2'((i >> 1) & 3);
        e.ras_type = 2'((i >> 2) & 3);
        e.target   = 39'(32'h0000_1000 + i * 8);
        e.fsq_idx  = 5'(i);
        return e;
    endfunction

    task automatic drive_br(input BranchUpdEntry e);
        br_en_i      = 1'b1;
        br_taken_i   = e.taken;
        br_type_i    = e.br_type;
        ras_type_i   = e.ras_type;
        br_target_i  = e.target;
        rd_fsq_idx_i = e.fsq_idx;
    endtask

    task automatic idle_inputs();
        rd_en_i = 1'b0; rd_csr_i = 1'b0; br_en_i = 1'b0;
    endtask

    vec_t tbl [18];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0; rd_en_i = 0; rd_csr_i = 0; rd_rob_idx_i = '0; rd_fsq_idx_i = '0;
        rd_target_i = '0; br_en_i = 0; br_taken_i = 0; br_type_i = '0; ras_type_i = '0;
        br_target_i = '0; bpu_rs_ready_i = 0; upd_ready_i = 0;

        // rd_en rd_csr robIdx fsq target rdy | flush restore rs_valid busy pc idx
        tbl[0]  = mkv(1,0,{1'b0,6'd10}, 5'd3, 39'h8000_0040,1, 0,0,0,0, 39'h0,          5'd0);
        tbl[1]  = mkv(0,0,7'd0,         5'd0, 39'h0,        1, 1,0,0,1, 39'h8000_0040, 5'd3);
        tbl[2]  = mkv(0,0,7'd0,         5'd0, 39'h0,        1, 1,1,0,1, 39'h8000_0040, 5'd3);
        tbl[3]  = mkv(0,0,7'd0,         5'd0, 39'h0,        1, 0,0,1,1, 39'h8000_0040, 5'd3);
        tbl[4]  = mkv(0,0,7'd0,         5'd0, 39'h0,        1, 0,0,0,0, 39'h8000_0040, 5'd3);
        tbl[5]  = mkv(1,0,{1'b0,6'd10}, 5'd7, 39'h1000,     0, 0,0,0,0, 39'h8000_0040, 5'd3);
        tbl[6]  = mkv(1,0,{1'b0,6'd5},  5'd8, 39'h2000,     0, 1,0,0,1, 39'h1000,      5'd7);
        tbl[7]  = mkv(0,0,7'd0,         5'd0, 39'h0,        0, 1,0,0,1, 39'h2000,      5'd8);
        tbl[8]  = mkv(1,0,{1'b0,6'd20}, 5'd9, 39'h3000,     0, 1,1,0,1, 39'h2000,      5'd8);
        tbl[9]  = mkv(1,0,{1'b1,6'd3},  5'd10,39'h4000,     0, 0,0,1,1, 39'h2000,      5'd8);
        tbl[10] = mkv(0,0,7'd0,         5'd0, 39'h0,        0, 0,0,1,1, 39'h2000,      5'd8);
        tbl[11] = mkv(1,0,{1'b0,6'd4},  5'd11,39'h5000,     1, 0,0,1,1, 39'h2000,      5'd8);
        tbl[12] = mkv(1,1,{1'b1,6'd2},  5'd12,39'h6000,     1, 1,0,0,1, 39'h5000,      5'd11);
        tbl[13] = mkv(1,0,{1'b0,6'd60}, 5'd13,39'h7000,     1, 1,0,0,1, 39'h6000,      5'd12);
        tbl[14] = mkv(1,0,{1'b0,6'd60}, 5'd14,39'h7100,     1, 1,0,0,1, 39'h7000,      5'd13);
        tbl[15] = mkv(0,0,7'd0,         5'd0, 39'h0,        1, 1,1,0,1, 39'h7000,      5'd13);
        tbl[16] = mkv(0,0,7'd0,         5'd0, 39'h0,        1, 0,0,1,1, 39'h7000,      5'd13);
        tbl[17] = mkv(0,0,7'd0,         5'd0, 39'h0,        1, 0,0,0,0, 39'h7000,      5'd13);

        // Reset state
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_flush", 64'(fe_flush_o), 64'd0);
        chk("rst_rs_valid", 64'(bpu_rs_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_upd_valid", 64'(upd_valid_o), 64'd0);
        chk("rst_upd_drop", 64'(upd_drop_o), 64'd0);
        rst_ni = 1'b1;

        // Redirect FSM, per-cycle vectors
        for (int k = 0; k < 18; k++) begin
            @(posedge clk_i); #1;
            rd_en_i = tbl[k].rd_en; rd_csr_i = tbl[k].csr; rd_rob_idx_i = tbl[k].rob;
            rd_fsq_idx_i = tbl[k].fsq; rd_target_i = tbl[k].tgt; bpu_rs_ready_i = tbl[k].rdy;
            @(negedge clk_i);
            chk($sformatf("v%0d_flush", k), 64'(fe_flush_o), 64'(tbl[k].e_flush));
            chk($sformatf("v%0d_restore", k), 64'(fsq_restore_en_o), 64'(tbl[k].e_rest));
            chk($sformatf("v%0d_rs_valid", k), 64'(bpu_rs_valid_o), 64'(tbl[k].e_rsv));
            chk($sformatf("v%0d_busy", k), 64'(busy_o), 64'(tbl[k].e_busy));
            chk($sformatf("v%0d_pc", k), 64'(bpu_rs_pc_o), 64'(tbl[k].e_pc));
            chk($sformatf("v%0d_idx", k), 64'(fsq_restore_idx_o), 64'(tbl[k].e_idx));
        end

        // CSR redirect with br_en: no FIFO push
        @(posedge clk_i); #1;
        rd_en_i = 1'b1; rd_csr_i = 1'b1; drive_br(mk(30)); upd_ready_i = 1'b0;
        @(posedge clk_i); #1;
        idle_inputs();
        @(negedge clk_i);
        chk("csr_no_push", 64'(upd_valid_o), 64'd0);

        // Fill 4, fifth dropped
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            drive_br(mk(i));
            @(negedge clk_i);
            chk($sformatf("fill%0d_drop", i), 64'(upd_drop_o), (i == 4) ? 64'd1 : 64'd0);
        end
        @(posedge clk_i); #1;
        idle_inputs(); upd_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk($sformatf("drain%0d_valid", i), 64'(upd_valid_o), 64'd1);
            chk($sformatf("drain%0d_data", i), 64'(upd_data_o), 64'(mk(i)));
            @(posedge clk_i); #1;
        end
        @(negedge clk_i);
        chk("drain_empty", 64'(upd_valid_o), 64'd0);

        // Full FIFO with simultaneous pop: push accepted, no drop
        upd_ready_i = 1'b0;
        for (int i = 10; i < 14; i++) begin
            @(posedge clk_i); #1;
            drive_br(mk(i));
            @(negedge clk_i);
            chk($sformatf("refill%0d_drop", i), 64'(upd_drop_o), 64'd0);
        end
        @(posedge clk_i); #1;
        drive_br(mk(14)); upd_ready_i = 1'b1;
        @(negedge clk_i);
        chk("full_pop_drop", 64'(upd_drop_o), 64'd0);
        chk("full_pop_head", 64'(upd_data_o), 64'(mk(10)));
        @(posedge clk_i); #1;
        idle_inputs();
        for (int i = 11; i < 15; i++) begin
            @(negedge clk_i);
            chk($sformatf("drain2_%0d_valid", i), 64'(upd_valid_o), 64'd1);
            chk($sformatf("drain2_%0d_data", i), 64'(upd_data_o), 64'(mk(i)));
            @(posedge clk_i); #1;
        end
        @(negedge clk_i);
        chk("drain2_empty", 64'(upd_valid_o), 64'd0);

        // Reset asserted while in RESTART with a queued update
        @(posedge clk_i); #1;
        rd_en_i = 1'b1; rd_rob_idx_i = 7'd1; rd_fsq_idx_i = 5'd21; rd_target_i = 39'h9000;
        drive_br(mk(21)); bpu_rs_ready_i = 1'b0; upd_ready_i = 1'b0;
        @(posedge clk_i); #1;
        idle_inputs();
        repeat (2) begin
            @(posedge clk_i); #1;
        end
        chk("pre_rst_rs_valid", 64'(bpu_rs_valid_o), 64'd1);
        chk("pre_rst_upd_valid", 64'(upd_valid_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk("arst_rs_valid", 64'(bpu_rs_valid_o), 64'd0);
        chk("arst_flush", 64'(fe_flush_o), 64'd0);
        chk("arst_restore", 64'(fsq_restore_en_o), 64'd0);
        chk("arst_restore_idx", 64'(fsq_restore_idx_o), 64'd0);
        chk("arst_pc", 64'(bpu_rs_pc_o), 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_upd_valid", 64'(upd_valid_o), 64'd0);
        chk("arst_upd_data", 64'(upd_data_o), 64'd0);
        chk("arst_upd_drop", 64'(upd_drop_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("post_rst_upd_valid", 64'(upd_valid_o), 64'd0);
        chk("post_rst_busy", 64'(busy_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
